// File: rtl/fft_input_split.sv
// -----------------------------------------------------------------------------
// fft_input_split
//
// Input reorder stage for the radix-2 MDC FFT pipeline, placed directly in
// front of dc_top. Serial complex samples arrive one per accepted cycle. The
// first half of each N-point symbol is parked in a N/2-entry buffer. While the
// second half streams in, each live sample x[i+N/2] is paired with its buffered
// partner x[i] and both are presented together on x0/x1.
//
// Optional feature macro: FFT_SPLIT_CP_STRIP_EN
//   When defined, the first CP_LEN accepted samples of every frame (the cyclic
//   prefix) are counted and discarded before the symbol is buffered.
//
// Parameters
//   N       FFT size, power of two, >= 8
//   CP_LEN  cyclic-prefix length (1..N), only acts with the macro defined
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high; discards any partial symbol
//   in_valid   x_in carries a sample this cycle (no backpressure)
//   x_in       serial input sample
//   x0         lane 0: buffered sample x[i]
//   x1         lane 1: live sample x[i+N/2]
//   out_valid  x0/x1 hold a valid pair
//   sym_start  high with pair i=0 of each symbol
//
// All outputs are registered; samples pass through bit-exact.
// -----------------------------------------------------------------------------

package fft_input_split_pkg;

  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } complex_product_t;

endpackage

module fft_input_split
  import fft_input_split_pkg::*;
#(
  parameter int N      = 128,
  parameter int CP_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  complex_product_t x_in,
  output complex_product_t x0,
  output complex_product_t x1,
  output logic             out_valid,
  output logic             sym_start
);

  localparam int HALF  = N / 2;
  localparam int IDX_W = $clog2(N);
  localparam int HLF_W = IDX_W - 1;

  // Reject illegal configurations at elaboration time.
  if (N < 8 || (N & (N - 1)) != 0 || CP_LEN < 1 || CP_LEN > N) begin : g_param_check
    $error("fft_input_split: N must be a power of two >= 8 and CP_LEN in 1..N");
  end

`ifdef FFT_SPLIT_CP_STRIP_EN
  typedef enum logic [1:0] {S_CP, S_FILL, S_PAIR} state_t;
  localparam state_t FRAME_START = S_CP;
  localparam int     CP_W        = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
  logic [CP_W-1:0]   cp_cnt;
`else
  typedef enum logic [1:0] {S_FILL, S_PAIR} state_t;
  localparam state_t FRAME_START = S_FILL;
`endif

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [HLF_W-1:0] half_idx;
  complex_product_t sample_buf [HALF];

  // In S_FILL idx < N/2, and in S_PAIR idx-N/2 is just idx without its MSB,
  // so the low bits address the buffer in both states.
  assign half_idx = idx[HLF_W-1:0];

  // First-half storage. No reset: contents are always overwritten before they
  // are read. Reset still blocks the write so a sample arriving with reset is
  // dropped.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && state == S_FILL) begin
      sample_buf[half_idx] <= x_in;
    end
  end

  // Frame sequencer and registered output pair. idx runs 0..N-1 across a
  // symbol (0..N/2-1 filling, N/2..N-1 pairing) and wraps to 0 at the end of
  // the symbol. Outputs default to zero every cycle so that idle cycles show
  // zeros rather than the previous pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FRAME_START;
      idx       <= '0;
      x0        <= '0;
      x1        <= '0;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
`ifdef FFT_SPLIT_CP_STRIP_EN
      cp_cnt    <= '0;
`endif
    end else begin
      x0        <= '0;
      x1        <= '0;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
      if (in_valid) begin
        unique case (state)
`ifdef FFT_SPLIT_CP_STRIP_EN
          S_CP: begin
            if (cp_cnt == CP_W'(CP_LEN - 1)) begin
              cp_cnt <= '0;
              state  <= S_FILL;
            end else begin
              cp_cnt <= cp_cnt + CP_W'(1);
            end
          end
`endif
          S_FILL: begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(HALF - 1)) begin
              state <= S_PAIR;
            end
          end
          S_PAIR: begin
            x0        <= sample_buf[half_idx];
            x1        <= x_in;
            out_valid <= 1'b1;
            sym_start <= (idx == IDX_W'(HALF));
            idx       <= idx + IDX_W'(1);
            if (idx == IDX_W'(N - 1)) begin
              state <= FRAME_START;
            end
          end
          default: begin
            state <= FRAME_START;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_input_split.sv
// -----------------------------------------------------------------------------
// tb_fft_input_split
//
// Self-checking bench for fft_input_split with N=8, CP_LEN=2. A vector table
// covers reset and the first symbol cycle by cycle; a scoreboard then covers
// back-to-back symbols, input gaps, mid-symbol reset, random valid patterns
// and (with FFT_SPLIT_CP_STRIP_EN) cyclic-prefix removal.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fft_input_split;
  import fft_input_split_pkg::*;

  localparam int N      = 8;
  localparam int CP_LEN = 2;
  localparam int HALF   = N / 2;
`ifdef FFT_SPLIT_CP_STRIP_EN
  localparam int CP = CP_LEN;
`else
  localparam int CP = 0;
`endif
  localparam int FRAME = N + CP;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  complex_product_t x_in;
  complex_product_t x0;
  complex_product_t x1;
  logic             out_valid;
  logic             sym_start;

  fft_input_split #(.N(N), .CP_LEN(CP_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .x0        (x0),
    .x1        (x1),
    .out_valid (out_valid),
    .sym_start (sym_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    complex_product_t a;
    complex_product_t b;
    logic             ss;
  } pair_t;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [31:0] val;
    bit          eov;
    logic [31:0] e0;
    logic [31:0] e1;
    bit          ess;
  } vec_t;

  pair_t            sb [$];
  vec_t             vecs [$];
  complex_product_t first_half [HALF];
  int               pos     = 0;
  int               cp_eff  = CP;
  bit               mon_en  = 1'b0;

  // Imag part is derived from the real part so both fields are checked.
  function automatic complex_product_t mkSample(logic [31:0] v);
    complex_product_t s;
    s.r = v;
    s.i = v ^ 32'hA5A5_0000;
    return s;
  endfunction

  task automatic checkOutput(string name, logic eov, complex_product_t e0,
                             complex_product_t e1, logic ess);
    checks++;
    if (out_valid !== eov || x0 !== e0 || x1 !== e1 || sym_start !== ess) begin
      errors++;
      $display("[TB] FAIL %s: got ov=%0b ss=%0b x0=%h x1=%h, want ov=%0b ss=%0b x0=%h x1=%h",
               name, out_valid, sym_start, x0, x1, eov, ess, e0, e1);
    end
  endtask

  // Drive one cycle (called at a falling edge) and update the reference frame
  // model: prefix samples are ignored, first-half samples are remembered and
  // second-half samples produce an expected pair.
  task automatic applyStimulus(bit rst, bit v, logic [31:0] val);
    int p;
    reset    = rst;
    in_valid = v;
    x_in     = mkSample(val);
    if (rst) begin
      pos = 0;
    end else if (v) begin
      if (pos >= cp_eff) begin
        p = pos - cp_eff;
        if (p < HALF) first_half[p] = x_in;
        else sb.push_back('{first_half[p-HALF], x_in, logic'(p == HALF)});
      end
      pos = (pos + 1) % FRAME;
    end
    @(negedge clk);
  endtask

  task automatic sendPrefix();
    for (int k = 0; k < cp_eff; k++) applyStimulus(1'b0, 1'b1, 32'(100 + k));
  endtask

  task automatic sendFrame(int base);
    sendPrefix();
    for (int k = 0; k < N; k++) applyStimulus(1'b0, 1'b1, 32'(base + k));
  endtask

  task automatic addRow(bit rst, bit vld, int val, bit eov, int e0, int e1, bit ess);
    vecs.push_back('{rst, vld, 32'(val), eov, 32'(e0), 32'(e1), ess});
  endtask

  // Scoreboard monitor: every cycle either a pair is due or outputs are zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pair: got x0=%h x1=%h, want no output", x0, x1);
        end else begin
          pair_t e;
          e = sb.pop_front();
          checkOutput("sb_pair", 1'b1, e.a, e.b, e.ss);
        end
      end else begin
        checkOutput("sb_idle", 1'b0, '0, '0, 1'b0);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;

    // Reset, then one gap-free symbol 0..7: pairs on the 5th..8th sample.
    addRow(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < CP; k++) addRow(0, 1, 100 + k, 0, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      if (k < HALF) addRow(0, 1, k, 0, 0, 0, 0);
      else          addRow(0, 1, k, 1, k - HALF, k, k == HALF);
    end
    addRow(0, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[n]) begin
      reset    = vecs[n].rst;
      in_valid = vecs[n].vld;
      x_in     = mkSample(vecs[n].val);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", n), vecs[n].eov,
                  vecs[n].eov ? mkSample(vecs[n].e0) : complex_product_t'('0),
                  vecs[n].eov ? mkSample(vecs[n].e1) : complex_product_t'('0),
                  vecs[n].ess);
    end

    mon_en = 1'b1;

    // Reset arriving together with a valid sample: the sample is dropped.
    applyStimulus(1'b1, 1'b1, 32'd99);

    // Back-to-back symbols 0..15, then idle.
    sendFrame(0);
    sendFrame(8);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);

    // in_valid dropped for 3 cycles after sample 2.
    sendPrefix();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'(30 + k));
    repeat (3) applyStimulus(1'b0, 1'b0, 32'hDEAD);
    for (int k = 3; k < N; k++) applyStimulus(1'b0, 1'b1, 32'(30 + k));
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset after the second pair, then a fresh symbol 20..27.
    sendPrefix();
    for (int k = 0; k < HALF + 2; k++) applyStimulus(1'b0, 1'b1, 32'(40 + k));
    applyStimulus(1'b1, 1'b1, 32'd77);
    sendFrame(20);

    // Random valid pattern and data across several frames.
    for (int c = 0; c < 120; c++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom);

    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
    mon_en = 1'b0;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending pairs, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
